// File: rtl/conv_block_sched.sv
// Block scheduler for the 2D convolution column engine: load / process / readout per block.
// Optional watchdog compiled in with `define CONV_SCHED_WDT_EN.
module conv_block_sched #(
  parameter int NB_IMAGE = 10,
  parameter int NB_BLOCK = 8,
  parameter int NB_WDT   = 16
) (
  input  logic                i_CLK,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [NB_IMAGE-1:0] i_imgLength,
  input  logic [NB_BLOCK-1:0] i_nBlocks,
  input  logic                i_changeBlock,
  input  logic                i_EoP,
  output logic                o_fsmReset,
  output logic [NB_IMAGE-1:0] o_imgLength,
  output logic                o_SoP,
  output logic [NB_BLOCK-1:0] o_blockIdx,
  output logic [1:0]          o_phase,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_error
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_LOAD, S_START, S_PROC, S_DRAIN, S_NEXT, S_DONE
  } state_t;

  state_t              state;
  logic                prev_change_block;
  logic                prev_eop;
  logic [NB_BLOCK-1:0] n_blocks;
  logic                change_edge;
  logic                eop_edge;

  assign change_edge = i_changeBlock & ~prev_change_block;
  assign eop_edge    = i_EoP & ~prev_eop;

`ifdef CONV_SCHED_WDT_EN
  logic [NB_WDT-1:0] wdt;
  logic              waiting;
  logic              error_q;

  assign waiting = ((state == S_LOAD)  && !change_edge) ||
                   ((state == S_PROC)  && !eop_edge)    ||
                   ((state == S_DRAIN) && !change_edge);
  assign o_error = error_q;
`else
  logic unused_wdt_cfg;
  assign unused_wdt_cfg = (NB_WDT > 0);
  assign o_error        = 1'b0;
`endif

  always_ff @(posedge i_CLK) begin
    if (i_reset) begin
      state             <= S_IDLE;
      prev_change_block <= 1'b0;
      prev_eop          <= 1'b0;
      n_blocks          <= '0;
      o_fsmReset        <= 1'b0;
      o_imgLength       <= '0;
      o_SoP             <= 1'b0;
      o_blockIdx        <= '0;
      o_phase           <= 2'd0;
      o_busy            <= 1'b0;
      o_done            <= 1'b0;
`ifdef CONV_SCHED_WDT_EN
      wdt               <= '0;
      error_q           <= 1'b0;
`endif
    end else begin
      prev_change_block <= i_changeBlock;
      prev_eop          <= i_EoP;
      o_fsmReset        <= 1'b0;
      o_SoP             <= 1'b0;
      o_done            <= 1'b0;
`ifdef CONV_SCHED_WDT_EN
      wdt               <= '0;
`endif
      case (state)
        S_IDLE: begin
          if (i_start) begin
            o_imgLength <= i_imgLength;
            n_blocks    <= i_nBlocks;
            o_blockIdx  <= '0;
            o_busy      <= 1'b1;
`ifdef CONV_SCHED_WDT_EN
            error_q     <= 1'b0;
`endif
            if (i_nBlocks == '0) begin
              state <= S_DONE;
            end else begin
              state      <= S_INIT;
              o_fsmReset <= 1'b1;
            end
          end
        end
        S_INIT: begin
          state   <= S_LOAD;
          o_phase <= 2'd1;
        end
        S_LOAD: begin
          if (change_edge) begin
            state <= S_START;
            o_SoP <= 1'b1;
          end
        end
        S_START: begin
          state   <= S_PROC;
          o_phase <= 2'd2;
        end
        S_PROC: begin
          // A coincident changeBlock edge is dropped here; prev_* already tracks it.
          if (eop_edge) begin
            state   <= S_DRAIN;
            o_phase <= 2'd3;
          end
        end
        S_DRAIN: begin
          if (change_edge) state <= S_NEXT;
        end
        S_NEXT: begin
          if (o_blockIdx == n_blocks - NB_BLOCK'(1)) begin
            state  <= S_DONE;
            o_done <= 1'b1;
          end else begin
            o_blockIdx <= o_blockIdx + NB_BLOCK'(1);
            state      <= S_INIT;
            o_fsmReset <= 1'b1;
          end
        end
        S_DONE: begin
          // Zero-block runs arrive without o_done set and spend one extra cycle here.
          if (!o_done) begin
            o_done <= 1'b1;
          end else begin
            state   <= S_IDLE;
            o_busy  <= 1'b0;
            o_phase <= 2'd0;
          end
        end
        default: state <= S_IDLE;
      endcase
`ifdef CONV_SCHED_WDT_EN
      if (waiting) begin
        if (&wdt) begin
          state   <= S_IDLE;
          error_q <= 1'b1;
          o_busy  <= 1'b0;
          o_phase <= 2'd0;
        end else begin
          wdt <= wdt + NB_WDT'(1);
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_conv_block_sched.sv
// Directed self-checking bench for conv_block_sched; covers the watchdog when
// CONV_SCHED_WDT_EN is defined.
module tb_conv_block_sched;

  localparam int NB_IMAGE = 10;
  localparam int NB_BLOCK = 8;
`ifdef CONV_SCHED_WDT_EN
  localparam int NB_WDT = 4;
`else
  localparam int NB_WDT = 16;
`endif
  localparam int GAP = 8;

  logic                i_CLK = 1'b0;
  logic                i_reset = 1'b0;
  logic                i_start = 1'b0;
  logic [NB_IMAGE-1:0] i_imgLength = '0;
  logic [NB_BLOCK-1:0] i_nBlocks = '0;
  logic                i_changeBlock = 1'b0;
  logic                i_EoP = 1'b0;
  logic                o_fsmReset;
  logic [NB_IMAGE-1:0] o_imgLength;
  logic                o_SoP;
  logic [NB_BLOCK-1:0] o_blockIdx;
  logic [1:0]          o_phase;
  logic                o_busy;
  logic                o_done;
  logic                o_error;

  int n_checks = 0;
  int n_fail   = 0;
  int rst_cnt  = 0;
  int sop_cnt  = 0;
  int done_cnt = 0;
  int rst_base, sop_base, done_base;

  conv_block_sched #(.NB_IMAGE(NB_IMAGE), .NB_BLOCK(NB_BLOCK), .NB_WDT(NB_WDT)) dut (
    .i_CLK(i_CLK), .i_reset(i_reset), .i_start(i_start), .i_imgLength(i_imgLength),
    .i_nBlocks(i_nBlocks), .i_changeBlock(i_changeBlock), .i_EoP(i_EoP),
    .o_fsmReset(o_fsmReset), .o_imgLength(o_imgLength), .o_SoP(o_SoP),
    .o_blockIdx(o_blockIdx), .o_phase(o_phase), .o_busy(o_busy), .o_done(o_done),
    .o_error(o_error)
  );

  always #5 i_CLK = ~i_CLK;

  // Pulse counters sampled mid-cycle, away from the active edge.
  always @(negedge i_CLK) begin
    if (o_fsmReset) rst_cnt++;
    if (o_SoP) sop_cnt++;
    if (o_done) done_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge i_CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int img, input int nb);
    i_imgLength = NB_IMAGE'(img);
    i_nBlocks   = NB_BLOCK'(nb);
    i_start     = 1'b1;
    tick(1);
    i_start     = 1'b0;
  endtask

  task automatic snapCounts();
    rst_base  = rst_cnt;
    sop_base  = sop_cnt;
    done_base = done_cnt;
  endtask

  task automatic checkIdleReset(input string tag);
    checkOutput({tag, "_fsmReset"}, 32'(o_fsmReset), 0);
    checkOutput({tag, "_SoP"}, 32'(o_SoP), 0);
    checkOutput({tag, "_done"}, 32'(o_done), 0);
    checkOutput({tag, "_error"}, 32'(o_error), 0);
    checkOutput({tag, "_busy"}, 32'(o_busy), 0);
    checkOutput({tag, "_phase"}, 32'(o_phase), 0);
    checkOutput({tag, "_blockIdx"}, 32'(o_blockIdx), 0);
    checkOutput({tag, "_imgLength"}, 32'(o_imgLength), 0);
  endtask

  // Starts in LOAD, ends one cycle after the final changeBlock edge (NEXT).
  task automatic runBlock(input string tag);
    tick(GAP);
    i_changeBlock = 1'b1;
    tick(1);
    checkOutput({tag, "_sop"}, 32'(o_SoP), 1);
    checkOutput({tag, "_phase_load"}, 32'(o_phase), 1);
    i_changeBlock = 1'b0;
    tick(1);
    checkOutput({tag, "_phase_proc"}, 32'(o_phase), 2);
    tick(GAP);
    i_EoP = 1'b1;
    tick(1);
    checkOutput({tag, "_phase_drain"}, 32'(o_phase), 3);
    i_EoP = 1'b0;
    tick(GAP);
    i_changeBlock = 1'b1;
    tick(1);
    i_changeBlock = 1'b0;
    checkOutput({tag, "_next_done"}, 32'(o_done), 0);
    checkOutput({tag, "_next_busy"}, 32'(o_busy), 1);
  endtask

  initial begin
    // Reset state
    i_reset = 1'b1;
    tick(2);
    checkIdleReset("reset");
    i_reset = 1'b0;
    tick(1);

    // Single block, imgLength 10
    snapCounts();
    applyStimulus(10, 1);
    checkOutput("b1_busy", 32'(o_busy), 1);
    checkOutput("b1_fsmReset", 32'(o_fsmReset), 1);
    checkOutput("b1_img", 32'(o_imgLength), 10);
    tick(1);
    checkOutput("b1_phase_t2", 32'(o_phase), 1);
    checkOutput("b1_fsmReset_t2", 32'(o_fsmReset), 0);
    runBlock("b1");
    tick(1);
    checkOutput("b1_done", 32'(o_done), 1);
    tick(1);
    checkOutput("b1_done_end", 32'(o_done), 0);
    checkOutput("b1_busy_end", 32'(o_busy), 0);
    checkOutput("b1_rst_pulses", 32'(rst_cnt - rst_base), 1);
    checkOutput("b1_sop_pulses", 32'(sop_cnt - sop_base), 1);
    checkOutput("b1_done_pulses", 32'(done_cnt - done_base), 1);

    // Three blocks
    snapCounts();
    applyStimulus(20, 3);
    tick(1);
    for (int b = 0; b < 3; b++) begin
      checkOutput($sformatf("b3_idx%0d", b), 32'(o_blockIdx), 32'(b));
      runBlock($sformatf("b3_blk%0d", b));
      tick(1);
      if (b < 2) begin
        checkOutput($sformatf("b3_idx_step%0d", b), 32'(o_blockIdx), 32'(b + 1));
        checkOutput($sformatf("b3_fsmReset%0d", b), 32'(o_fsmReset), 1);
        checkOutput($sformatf("b3_nodone%0d", b), 32'(o_done), 0);
        tick(1);
      end else begin
        checkOutput("b3_done", 32'(o_done), 1);
      end
    end
    tick(2);
    checkOutput("b3_busy_end", 32'(o_busy), 0);
    checkOutput("b3_rst_pulses", 32'(rst_cnt - rst_base), 3);
    checkOutput("b3_sop_pulses", 32'(sop_cnt - sop_base), 3);
    checkOutput("b3_done_pulses", 32'(done_cnt - done_base), 1);

    // Zero blocks
    snapCounts();
    applyStimulus(5, 0);
    checkOutput("z_busy_t1", 32'(o_busy), 1);
    checkOutput("z_done_t1", 32'(o_done), 0);
    tick(1);
    checkOutput("z_done_t2", 32'(o_done), 1);
    tick(1);
    checkOutput("z_done_t3", 32'(o_done), 0);
    checkOutput("z_busy_t3", 32'(o_busy), 0);
    checkOutput("z_rst_pulses", 32'(rst_cnt - rst_base), 0);
    checkOutput("z_sop_pulses", 32'(sop_cnt - sop_base), 0);

    // Held levels, wrong-phase edges, ignored start, simultaneous edges
    snapCounts();
    applyStimulus(7, 1);
    tick(1);
    i_EoP = 1'b1;
    tick(2);
    i_EoP = 1'b0;
    tick(1);
    checkOutput("w_eop_in_load", 32'(o_phase), 1);
    i_changeBlock = 1'b1;
    tick(2);
    checkOutput("w_phase_proc", 32'(o_phase), 2);
    tick(5);
    checkOutput("w_held_cb_sop", 32'(sop_cnt - sop_base), 1);
    applyStimulus(9, 0);
    i_changeBlock = 1'b0;
    tick(1);
    i_changeBlock = 1'b1;
    tick(1);
    checkOutput("w_cb_in_proc", 32'(o_phase), 2);
    checkOutput("w_start_ignored_img", 32'(o_imgLength), 7);
    i_changeBlock = 1'b0;
    tick(1);
    i_changeBlock = 1'b1;
    i_EoP = 1'b1;
    tick(1);
    checkOutput("w_simul_drain", 32'(o_phase), 3);
    tick(3);
    checkOutput("w_cb_consumed_phase", 32'(o_phase), 3);
    checkOutput("w_cb_consumed_done", 32'(done_cnt - done_base), 0);
    i_EoP = 1'b0;
    tick(1);
    i_EoP = 1'b1;
    tick(1);
    checkOutput("w_eop_in_drain", 32'(o_phase), 3);
    i_EoP = 1'b0;
    i_changeBlock = 1'b0;
    tick(1);
    i_changeBlock = 1'b1;
    tick(2);
    i_changeBlock = 1'b0;
    checkOutput("w_done", 32'(o_done), 1);
    tick(4);
    checkOutput("w_busy_end", 32'(o_busy), 0);
    checkOutput("w_rst_pulses", 32'(rst_cnt - rst_base), 1);
    checkOutput("w_sop_pulses", 32'(sop_cnt - sop_base), 1);

    // Reset in PROC of block 1 of 3, then a fresh run
    snapCounts();
    applyStimulus(12, 3);
    tick(1);
    runBlock("r_blk0");
    tick(2);
    i_changeBlock = 1'b1;
    tick(1);
    i_changeBlock = 1'b0;
    tick(1);
    checkOutput("r_phase_proc", 32'(o_phase), 2);
    checkOutput("r_idx1", 32'(o_blockIdx), 1);
    i_reset = 1'b1;
    tick(1);
    checkIdleReset("r_mid");
    i_reset = 1'b0;
    tick(5);
    checkOutput("r_no_done", 32'(done_cnt - done_base), 0);
    applyStimulus(3, 1);
    checkOutput("r_fresh_fsmReset", 32'(o_fsmReset), 1);
    tick(1);
    runBlock("r_fresh");
    tick(1);
    checkOutput("r_fresh_done", 32'(o_done), 1);
    tick(1);
    checkOutput("r_fresh_img", 32'(o_imgLength), 3);

`ifdef CONV_SCHED_WDT_EN
    // Watchdog: withhold EoP in PROC
    snapCounts();
    applyStimulus(4, 1);
    tick(1);
    i_changeBlock = 1'b1;
    tick(1);
    i_changeBlock = 1'b0;
    tick(1);
    checkOutput("wdt_phase_proc", 32'(o_phase), 2);
    tick(15);
    checkOutput("wdt_err_before", 32'(o_error), 0);
    checkOutput("wdt_busy_before", 32'(o_busy), 1);
    tick(1);
    checkOutput("wdt_err", 32'(o_error), 1);
    checkOutput("wdt_busy_idle", 32'(o_busy), 0);
    checkOutput("wdt_phase_idle", 32'(o_phase), 0);
    tick(3);
    checkOutput("wdt_err_sticky", 32'(o_error), 1);
    checkOutput("wdt_no_done", 32'(done_cnt - done_base), 0);
    applyStimulus(4, 0);
    checkOutput("wdt_err_clear", 32'(o_error), 0);
    tick(3);
`else
    checkOutput("no_wdt_error", 32'(o_error), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
